// File: rtl/maf_sched_if.sv
// Requester and maf-side bus of maf_sched.
// Handshake semantics: a requester raises req_vld[i] with its operands and
// keeps all of them stable until it observes req_gnt[i] high in the same
// cycle; that cycle is the acceptance. The maf side has no back-pressure:
// maf_op_vld is a one-cycle issue strobe, maf_res_rdy a one-cycle result
// strobe, and rsp_vld[i] a one-cycle response strobe qualifying rsp_res.
interface maf_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_vld;
  logic [NREQ-1:0]    req_nj_mode;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [32*NREQ-1:0] req_c;
  logic [NREQ-1:0]    req_gnt;
  logic               maf_op_vld;
  logic               maf_nj_mode;
  logic [31:0]        maf_a;
  logic [31:0]        maf_b;
  logic [31:0]        maf_c;
  logic [31:0]        maf_res;
  logic               maf_res_rdy;
  logic [NREQ-1:0]    rsp_vld;
  logic [31:0]        rsp_res;

  // Scheduler view
  modport slave (
    input  req_vld, req_nj_mode, req_a, req_b, req_c, maf_res, maf_res_rdy,
    output req_gnt, maf_op_vld, maf_nj_mode, maf_a, maf_b, maf_c, rsp_vld, rsp_res
  );

  // Requesters plus maf view
  modport master (
    output req_vld, req_nj_mode, req_a, req_b, req_c, maf_res, maf_res_rdy,
    input  req_gnt, maf_op_vld, maf_nj_mode, maf_a, maf_b, maf_c, rsp_vld, rsp_res
  );
endinterface

// File: rtl/maf_sched.sv
// maf_sched: round-robin scheduler sharing one fully pipelined maf between
// NREQ requesters. Accepted ops are registered onto the maf port, their
// owner tag travels down a MAF_LAT-deep tag pipeline, and the result is
// registered and strobed back to the owner MAF_LAT+2 cycles after acceptance.
// Optional build macro MAF_SCHED_CHK_EN: enables the sticky err flag that
// trips when maf_res_rdy disagrees with the tag pipeline head.
module maf_sched #(
  parameter int NREQ    = 4,
  parameter int MAF_LAT = 4,
  parameter int TAGW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  maf_sched_if.slave bus,
  output logic       busy,
  output logic       err
);

  logic [TAGW-1:0]    ptr_q, ptr_d;
  logic               gnt_any;
  logic [TAGW-1:0]    gnt_idx;
  logic [NREQ-1:0]    gnt;
  int                 j;

  logic               op_vld_q;
  logic               nj_q;
  logic [31:0]        a_q, b_q, c_q;
  logic [TAGW-1:0]    iss_tag_q;

  logic [MAF_LAT-1:0] tvld_q;
  logic [TAGW-1:0]    ttag_q [MAF_LAT];
  logic               head_vld;
  logic [TAGW-1:0]    head_tag;

  logic [NREQ-1:0]    rsp_vld_q, rsp_vld_d;
  logic [31:0]        rsp_res_q;

  assign head_vld = tvld_q[MAF_LAT-1];
  assign head_tag = ttag_q[MAF_LAT-1];

  // Round-robin search starting at ptr; no grant at all while in reset
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!rst && !gnt_any && bus.req_vld[j]) begin
        gnt_any = 1'b1;
        gnt_idx = TAGW'(j);
      end
    end
  end

  // One-hot grant and the pointer that follows the winner
  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == TAGW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Response strobe steered to the owner of the head tag
  always_comb begin
    rsp_vld_d = '0;
    if (head_vld) rsp_vld_d[head_tag] = 1'b1;
  end

  // Arbitration pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Issue register: op strobe every cycle, operands held when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      op_vld_q  <= 1'b0;
      nj_q      <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      iss_tag_q <= '0;
    end else begin
      op_vld_q <= gnt_any;
      if (gnt_any) begin
        nj_q      <= bus.req_nj_mode[gnt_idx];
        a_q       <= bus.req_a[32*gnt_idx +: 32];
        b_q       <= bus.req_b[32*gnt_idx +: 32];
        c_q       <= bus.req_c[32*gnt_idx +: 32];
        iss_tag_q <= gnt_idx;
      end
    end
  end

  // Tag pipeline valid bits; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      tvld_q <= '0;
    end else begin
      tvld_q[0] <= op_vld_q;
      for (int k = 1; k < MAF_LAT; k++) tvld_q[k] <= tvld_q[k-1];
    end
  end

  // Tag pipeline payload; only meaningful where the matching valid bit is set
  always_ff @(posedge clk) begin
    ttag_q[0] <= iss_tag_q;
    for (int k = 1; k < MAF_LAT; k++) ttag_q[k] <= ttag_q[k-1];
  end

  // Response register: capture maf result when the head stage is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q <= '0;
      rsp_res_q <= '0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      if (head_vld) rsp_res_q <= bus.maf_res;
    end
  end

`ifdef MAF_SCHED_CHK_EN
  logic err_q;

  // Sticky check: maf result strobe must line up with the head tag
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | (bus.maf_res_rdy != head_vld);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.req_gnt     = gnt;
  assign bus.maf_op_vld  = op_vld_q;
  assign bus.maf_nj_mode = nj_q;
  assign bus.maf_a       = a_q;
  assign bus.maf_b       = b_q;
  assign bus.maf_c       = c_q;
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_res     = rsp_res_q;
  assign busy            = op_vld_q | (|tvld_q);

endmodule

// File: doc/maf_sched.md
MAF_SCHED -- requirements
Module: maf_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one maf instance.
REQ-002 Parameter MAF_LAT, default 4, cycles from maf op_vld to maf res_rdy.
REQ-003 Parameter TAGW, default 2, requester tag width; TAGW SHALL satisfy 2**TAGW >= NREQ.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_vld  input  NREQ  per-requester operation request; held high until granted.
REQ-007 req_nj_mode  input  NREQ  per-requester nj_mode (1 = non-Java mode, 0 = Java mode).
REQ-008 req_a, req_b, req_c  input  32*NREQ each  per-requester operands; requester i occupies bits [32i+31:32i].
REQ-009 req_gnt  output  NREQ  one-hot grant; an operation is accepted when req_vld[i] and req_gnt[i] are both high.
REQ-010 maf_op_vld, maf_nj_mode  output  1 each  drive the maf op_vld and nj_mode inputs.
REQ-011 maf_a, maf_b, maf_c  output  32 each  drive the maf operands.
REQ-012 maf_res  input  32  maf result.
REQ-013 maf_res_rdy  input  1  maf result valid.
REQ-014 rsp_vld  output  NREQ  one-hot response strobe to the owning requester.
REQ-015 rsp_res  output  32  response data, valid while any rsp_vld bit is high.
REQ-016 busy  output  1  high while any operation is issued and not yet responded.
REQ-017 err  output  1  sticky protocol-check flag (see Configuration).

Function
REQ-018 req_gnt SHALL be combinational from req_vld and the round-robin pointer: at most one bit high; no bit high when req_vld is 0.
REQ-019 Arbitration SHALL search from index ptr upward, modulo NREQ, and grant the first requester with req_vld set.
REQ-020 ptr SHALL update to (granted index + 1) mod NREQ on acceptance and hold otherwise; wrap from NREQ-1 to 0.
REQ-021 The block SHALL accept one operation per cycle, with no back-pressure from the maf, which is fully pipelined.
REQ-022 An operation accepted in cycle t SHALL appear on maf_op_vld, maf_nj_mode, maf_a, maf_b and maf_c in cycle t+1, as registered outputs.
REQ-023 maf_op_vld SHALL be low in any cycle following a cycle with no acceptance; the maf operand registers SHALL hold their last values.
REQ-024 A tag pipeline of MAF_LAT stages of {valid, tag} SHALL load {1, granted index} at issue, shift every cycle, and load {0, x} when there is no issue.
REQ-025 When the head stage is valid (cycle t+1+MAF_LAT), rsp_res SHALL register maf_res and rsp_vld SHALL pulse for one cycle on the head tag at t+2+MAF_LAT.
REQ-026 Responses SHALL return in issue order; end-to-end latency from acceptance to rsp_vld SHALL be MAF_LAT+2 cycles.
REQ-027 busy SHALL be the OR of maf_op_vld and all tag pipeline valid bits.
REQ-028 Simultaneous acceptance and response in the same cycle SHALL both complete without interference.

Reset
REQ-029 While rst is high, ptr=0, all tag valid bits=0, maf_op_vld=0, maf_nj_mode=1, maf_a/b/c=0, rsp_vld=0, rsp_res=0 and err=0; req_gnt SHALL be forced to 0.
REQ-030 Reset mid-operation SHALL discard all in-flight tags; no rsp_vld SHALL be issued for operations accepted before reset, even if maf_res_rdy arrives afterwards.

Configuration
REQ-031 With MAF_SCHED_CHK_EN defined, err SHALL set when maf_res_rdy differs from the head-stage valid bit, and hold until rst.
REQ-032 With MAF_SCHED_CHK_EN undefined, err SHALL be tied to 0 and maf_res_rdy ignored; responses SHALL depend solely on the tag pipeline.

Verification
REQ-033 Requester 0 issues a=0x40000000, b=0x40400000, c=0x40800000, nj_mode=1 -> maf_op_vld at t+1 with the same operands; rsp_vld[0] with rsp_res=0x41200000 at t+6.
REQ-034 All four req_vld high in one cycle with ptr=0 -> grants 0,1,2,3 on four consecutive cycles; rsp_vld 0,1,2,3 on cycles t+6..t+9.
REQ-035 req_vld[0] and req_vld[2] held continuously -> grants alternate 0,2,0,2; neither starves.
REQ-036 Requester 1 issues with nj_mode=0 -> maf_nj_mode=0 in the issue cycle; the response is routed only to rsp_vld[1].
REQ-037 rst asserted 2 cycles after an acceptance -> busy=0 the cycle after rst; no rsp_vld is issued.
REQ-038 With MAF_SCHED_CHK_EN defined, maf_res_rdy is pulsed with no operation in flight -> err=1 next cycle and stays 1 until rst.
